gate_truth_table_sequencer: RTL and testbench



---
 rtl/gate_truth_table_sequencer.sv | 142 ++++++++++++++
 tb/tb_gate_truth_table_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_table_sequencer.sv
// Sweeps a 2-input gate through vectors 00..11, samples its output after
// a settle window and scores it against the selected truth table.
module gate_truth_table_sequencer #(
  parameter int unsigned DWELL_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] op_sel,
  input  logic       gate_y,
  output logic       gate_a,
  output logic       gate_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic [1:0] vec_idx
);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL_CYCLES - 1);

  state_t     state, state_nx;
  logic [1:0] op_q, op_nx;
  logic [7:0] dwell, dwell_nx;
  logic [1:0] vec_nx;
  logic [3:0] fail_nx;
  logic       pass_nx;
  logic       a_nx, b_nx;
  logic       expect_y;

  assign busy = (state == APPLY) || (state == SAMPLE);
  assign done = (state == DONE);

  always_comb begin
    expect_y = 1'b0;
    unique case (op_q)
      2'b00: expect_y = vec_idx[1] & vec_idx[0];
      2'b01: expect_y = vec_idx[1] | vec_idx[0];
      2'b10: expect_y = vec_idx[1] ^ vec_idx[0];
      2'b11: expect_y = ~(vec_idx[1] & vec_idx[0]);
      default: expect_y = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    op_nx    = op_q;
    dwell_nx = dwell;
    vec_nx   = vec_idx;
    fail_nx  = fail_vec;
    pass_nx  = pass;
    a_nx     = gate_a;
    b_nx     = gate_b;
    unique case (state)
      IDLE: begin
        a_nx = 1'b0;
        b_nx = 1'b0;
        if (start) begin
          op_nx    = op_sel;
          fail_nx  = 4'b0000;
          pass_nx  = 1'b0;
          vec_nx   = 2'b00;
          dwell_nx = 8'd0;
          state_nx = APPLY;
        end
      end
      APPLY: begin
        if (abort) begin
          state_nx = IDLE;
          a_nx     = 1'b0;
          b_nx     = 1'b0;
          pass_nx  = 1'b0;
          dwell_nx = 8'd0;
        end else begin
          dwell_nx = dwell + 8'd1;
          if (dwell == DWELL_LAST) state_nx = SAMPLE;
        end
      end
      SAMPLE: begin
        if (abort) begin
          // sample in this cycle is dropped
          state_nx = IDLE;
          a_nx     = 1'b0;
          b_nx     = 1'b0;
          pass_nx  = 1'b0;
          dwell_nx = 8'd0;
        end else begin
          if (gate_y != expect_y) fail_nx[vec_idx] = 1'b1;
          if (vec_idx == 2'd3) begin
            state_nx = DONE;
            pass_nx  = (fail_nx == 4'b0000);
            a_nx     = 1'b0;
            b_nx     = 1'b0;
          end else begin
            vec_nx   = vec_idx + 2'd1;
            dwell_nx = 8'd0;
            a_nx     = vec_nx[1];
            b_nx     = vec_nx[0];
            state_nx = APPLY;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
        a_nx     = 1'b0;
        b_nx     = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= 2'b00;
      dwell    <= 8'd0;
      vec_idx  <= 2'b00;
      fail_vec <= 4'b0000;
      pass     <= 1'b0;
      gate_a   <= 1'b0;
      gate_b   <= 1'b0;
    end else begin
      state    <= state_nx;
      op_q     <= op_nx;
      dwell    <= dwell_nx;
      vec_idx  <= vec_nx;
      fail_vec <= fail_nx;
      pass     <= pass_nx;
      gate_a   <= a_nx;
      gate_b   <= b_nx;
    end
  end

endmodule

// File: tb/tb_gate_truth_table_sequencer.sv
// Directed bench: an AND gate (optionally stuck at 0) behind two
// sequencers, one with a 4-cycle and one with a 1-cycle settle window.
module tb_gate_truth_table_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start4 = 0, abort4 = 0, stuck = 0;
  logic [1:0] op4 = 0;
  logic       y4, a4, b4, busy4, done4, pass4;
  logic [3:0] fail4;
  logic [1:0] vec4;

  logic       start1 = 0, abort1 = 0;
  logic [1:0] op1 = 0;
  logic       y1, a1, b1, busy1, done1, pass1;
  logic [3:0] fail1;
  logic [1:0] vec1;

  assign y4 = stuck ? 1'b0 : (a4 & b4);
  assign y1 = a1 & b1;

  gate_truth_table_sequencer #(.DWELL_CYCLES(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
    .op_sel(op4), .gate_y(y4), .gate_a(a4), .gate_b(b4),
    .busy(busy4), .done(done4), .pass(pass4), .fail_vec(fail4),
    .vec_idx(vec4)
  );

  gate_truth_table_sequencer #(.DWELL_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .op_sel(op1), .gate_y(y1), .gate_a(a1), .gate_b(b1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_vec(fail1),
    .vec_idx(vec1)
  );

  int checks = 0;
  int errors = 0;

  int         lat;
  int         done_cnt;
  logic [3:0] fv_s;
  logic       ps_s;
  logic [1:0] trace [0:40];
  logic       busy_tr [0:40];

  // cycle k is the k-th cycle after the edge that samples start
  task automatic sweep(input logic [1:0] op, input int restart_at,
                       input int abort_at);
    lat = 0;
    done_cnt = 0;
    @(negedge clk);
    op4 = op;
    start4 = 1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      trace[k] = {a4, b4};
      busy_tr[k] = busy4;
      if (done4) begin
        done_cnt++;
        if (lat == 0) begin
          lat = k;
          fv_s = fail4;
          ps_s = pass4;
        end
      end
      start4 = (k == restart_at);
      abort4 = (k == abort_at);
      op4 = ~op;
    end
    start4 = 0;
    abort4 = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #12;
    checks++;
    if ({a4, b4, busy4, done4, pass4, fail4, vec4} !== 11'd0) begin
      errors++;
      $display("FAIL reset_d4 got=%b want=0",
               {a4, b4, busy4, done4, pass4, fail4, vec4});
    end
    checks++;
    if ({a1, b1, busy1, done1, pass1, fail1, vec1} !== 11'd0) begin
      errors++;
      $display("FAIL reset_d1 got=%b want=0",
               {a1, b1, busy1, done1, pass1, fail1, vec1});
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_and();
    logic [1:0] want;
    stuck = 0;
    sweep(2'b00, 0, 0);
    checks++;
    if (lat !== 21) begin
      errors++;
      $display("FAIL and_latency got=%0d want=21", lat);
    end
    checks++;
    if (fv_s !== 4'b0000 || ps_s !== 1'b1) begin
      errors++;
      $display("FAIL and_result got=%b/%b want=0000/1", fv_s, ps_s);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL and_done_pulse got=%0d want=1", done_cnt);
    end
    for (int k = 1; k <= 21; k++) begin
      want = (k <= 20) ? 2'((k - 1) / 5) : 2'b00;
      checks++;
      if (trace[k] !== want || busy_tr[k] !== (k <= 20)) begin
        errors++;
        $display("FAIL and_vector cyc=%0d got=%b/%b want=%b/%b",
                 k, trace[k], busy_tr[k], want, k <= 20);
      end
    end
  endtask

  task automatic test_stuck();
    stuck = 1;
    sweep(2'b00, 0, 0);
    stuck = 0;
    checks++;
    if (lat !== 21 || fv_s !== 4'b1000 || ps_s !== 1'b0) begin
      errors++;
      $display("FAIL stuck got=%0d/%b/%b want=21/1000/0", lat, fv_s, ps_s);
    end
  endtask

  task automatic test_xor_nand();
    sweep(2'b10, 0, 0);
    checks++;
    if (lat !== 21 || fv_s !== 4'b1110 || ps_s !== 1'b0) begin
      errors++;
      $display("FAIL xor got=%0d/%b/%b want=21/1110/0", lat, fv_s, ps_s);
    end
    sweep(2'b11, 0, 0);
    checks++;
    if (lat !== 21 || fv_s !== 4'b1111 || ps_s !== 1'b0) begin
      errors++;
      $display("FAIL nand got=%0d/%b/%b want=21/1111/0", lat, fv_s, ps_s);
    end
    checks++;
    if (fail4 !== 4'b1111 || pass4 !== 1'b0 || busy4 !== 1'b0) begin
      errors++;
      $display("FAIL nand_hold got=%b/%b/%b want=1111/0/0",
               fail4, pass4, busy4);
    end
  endtask

  task automatic test_interrupt();
    sweep(2'b00, 7, 0);
    checks++;
    if (lat !== 21 || done_cnt !== 1 || fv_s !== 4'b0000 || ps_s !== 1'b1) begin
      errors++;
      $display("FAIL restart_ignored got=%0d/%0d/%b/%b want=21/1/0000/1",
               lat, done_cnt, fv_s, ps_s);
    end
    checks++;
    if (trace[7] !== 2'b01 || trace[12] !== 2'b10) begin
      errors++;
      $display("FAIL restart_trace got=%b/%b want=01/10", trace[7], trace[12]);
    end
    sweep(2'b00, 0, 12);
    checks++;
    if (trace[12] !== 2'b10 || busy_tr[12] !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre got=%b/%b want=10/1", trace[12], busy_tr[12]);
    end
    checks++;
    if (trace[13] !== 2'b00 || busy_tr[13] !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got=%b/%b want=00/0", trace[13], busy_tr[13]);
    end
    checks++;
    if (done_cnt !== 0 || pass4 !== 1'b0 || fail4 !== 4'b0000) begin
      errors++;
      $display("FAIL abort_result got=%0d/%b/%b want=0/0/0000",
               done_cnt, pass4, fail4);
    end
  endtask

  task automatic test_back_to_back();
    int d0, d1;
    d0 = 0;
    d1 = 0;
    @(negedge clk);
    op4 = 2'b00;
    start4 = 1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (done4) begin
        if (d0 == 0) d0 = k;
        else if (d1 == 0) d1 = k;
      end
    end
    start4 = 0;
    checks++;
    if (d0 !== 21 || d1 !== 43) begin
      errors++;
      $display("FAIL back_to_back got=%0d/%0d want=21/43", d0, d1);
    end
    repeat (25) @(negedge clk);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    start4 = 1;
    op4 = 2'b00;
    @(negedge clk);
    start4 = 0;
    repeat (16) @(negedge clk);
    checks++;
    if ({a4, b4, busy4, vec4} !== 5'b11111) begin
      errors++;
      $display("FAIL pre_reset got=%b want=11111", {a4, b4, busy4, vec4});
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({a4, b4, busy4, done4, pass4, fail4, vec4} !== 11'd0) begin
      errors++;
      $display("FAIL async_reset got=%b want=0",
               {a4, b4, busy4, done4, pass4, fail4, vec4});
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_dwell1();
    int l1;
    int bad;
    logic [1:0] want;
    l1 = 0;
    bad = 0;
    @(negedge clk);
    op1 = 2'b00;
    start1 = 1;
    abort1 = 1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      start1 = 0;
      abort1 = 0;
      want = (k <= 8) ? 2'((k - 1) / 2) : 2'b00;
      if (k <= 9 && {a1, b1} !== want) bad++;
      if (done1 && l1 == 0) begin
        l1 = k;
        checks++;
        if (fail1 !== 4'b0000 || pass1 !== 1'b1) begin
          errors++;
          $display("FAIL d1_result got=%b/%b want=0000/1", fail1, pass1);
        end
      end
    end
    checks++;
    if (l1 !== 9) begin
      errors++;
      $display("FAIL d1_latency got=%0d want=9", l1);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL d1_vectors got=%0d bad want=0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_and();
    test_stuck();
    test_xor_nand();
    test_interrupt();
    test_back_to_back();
    test_async_reset();
    test_dwell1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
